// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC accumulator datapath.
package mac_pkg;

  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_add_sat.sv
// Combinational accumulate adder: acc + zero-extended product, with carry out.
// Build option MAC_SAT_EN: clamp the sum to all-ones when the add carries out.
module mac_add_sat #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_full;

  // One extra bit on the adder captures the carry out of the accumulator MSB.
  always_comb begin
    w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    o_carry = w_full[ACC_W];
`ifdef MAC_SAT_EN
    o_sum   = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    o_sum   = w_full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accum16.sv
// Accumulates a programmed number of multiplier products into a wide sum.
// The product is registered before the add to split multiplier/adder paths.
// Build option MAC_SAT_EN (in mac_add_sat): saturate instead of wrapping.
module mac_accum16
  import mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_prod_valid,
  input  logic [PROD_W-1:0] i_prod,
  output logic              o_prod_ready,
  output logic [ACC_W-1:0]  o_acc_out,
  output logic              o_acc_valid,
  input  logic              i_acc_ack,
  output logic              o_busy,
  output logic              o_ovf,
  output logic [LEN_W-1:0]  o_count
);

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_count;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;
  logic [PROD_W-1:0]   r_pipe;
  logic                r_pipe_v;

  logic                w_xfer;
  logic [LEN_W-1:0]    w_count_nxt;
  logic [ACC_W-1:0]    w_sum;
  logic                w_carry;

  mac_add_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_prod  (r_pipe),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Handshake and status decode, all from registered state.
  always_comb begin
    o_prod_ready = (r_state == ACCUM) && (r_count < r_len);
    w_xfer       = o_prod_ready && i_prod_valid;
    w_count_nxt  = r_count + 1'b1;
    o_acc_valid  = (r_state == DONE);
    o_busy       = (r_state != IDLE);
    o_acc_out    = r_acc;
    o_ovf        = r_ovf;
    o_count      = r_count;
  end

  // Pipe register, add stage and job FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_pipe   <= '0;
      r_pipe_v <= 1'b0;
    end else begin
      r_pipe_v <= w_xfer;
      if (w_xfer) r_pipe <= i_prod;
      if (r_pipe_v) begin
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_carry;
      end
      case (r_state)
        IDLE: if (i_start) begin
          // A new job starts from a clean sum; len=0 goes straight to a zero result.
          r_len    <= i_len;
          r_acc    <= '0;
          r_count  <= '0;
          r_ovf    <= 1'b0;
          r_pipe_v <= 1'b0;
          r_state  <= (i_len == '0) ? DONE : ACCUM;
        end
        ACCUM: if (w_xfer) begin
          r_count <= w_count_nxt;
          if (w_count_nxt == r_len) r_state <= DRAIN;
        end
        // The last product sits in the pipe register; it lands in r_acc this edge.
        DRAIN: r_state <= DONE;
        DONE:  if (i_acc_ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum16.sv
// Directed bench for mac_accum16: main 40-bit instance plus a 32-bit
// accumulator instance sharing the same stimulus for the wrap/saturate case.
module tb_mac_accum16;

  logic        clk, rst;
  logic        start, prod_valid, acc_ack;
  logic [7:0]  len;
  logic [31:0] prod;

  logic        prod_ready, acc_valid, busy, ovf;
  logic [39:0] acc_out;
  logic [7:0]  count;

  logic        s_prod_ready, s_acc_valid, s_busy, s_ovf;
  logic [31:0] s_acc_out;
  logic [7:0]  s_count;

  int n_cmp = 0;
  int n_bad = 0;

  mac_accum16 dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .i_prod_valid(prod_valid), .i_prod(prod), .o_prod_ready(prod_ready),
    .o_acc_out(acc_out), .o_acc_valid(acc_valid), .i_acc_ack(acc_ack),
    .o_busy(busy), .o_ovf(ovf), .o_count(count)
  );

  mac_accum16 #(.ACC_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .i_prod_valid(prod_valid), .i_prod(prod), .o_prod_ready(s_prod_ready),
    .o_acc_out(s_acc_out), .o_acc_valid(s_acc_valid), .i_acc_ack(acc_ack),
    .o_busy(s_busy), .o_ovf(s_ovf), .o_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".acc_out"}, 64'(acc_out), 64'h0);
    chk({tag, ".count"}, 64'(count), 64'h0);
    chk({tag, ".busy"}, 64'(busy), 64'h0);
    chk({tag, ".ready"}, 64'(prod_ready), 64'h0);
    chk({tag, ".valid"}, 64'(acc_valid), 64'h0);
    chk({tag, ".ovf"}, 64'(ovf), 64'h0);
  endtask

  int gaps [4] = '{0, 2, 1, 3};

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; acc_ack = 1'b0;
    #3;
    chk_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Basic sum, back-to-back transfers.
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'hFE01;
    tick(); tick(); tick();
    prod_valid = 1'b0;
    chk("basic.ready_after_last", 64'(prod_ready), 64'h0);
    chk("basic.valid_plus1", 64'(acc_valid), 64'h0);
    tick();
    chk("basic.valid_plus2", 64'(acc_valid), 64'h1);
    chk("basic.acc", 64'(acc_out), 64'h2FA03);
    chk("basic.ovf", 64'(ovf), 64'h0);
    chk("basic.count", 64'(count), 64'h3);
    acc_ack = 1'b1; tick(); acc_ack = 1'b0;
    chk("basic.ack_valid", 64'(acc_valid), 64'h0);
    chk("basic.ack_busy", 64'(busy), 64'h0);

    // Gaps on prod_valid, then valid held with extra data that must be dropped.
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) tick();
      prod_valid = 1'b1; prod = 32'(i + 1);
      tick();
    end
    prod = 32'd100;
    chk("gaps.ready_after_4", 64'(prod_ready), 64'h0);
    tick(); tick();
    chk("gaps.valid", 64'(acc_valid), 64'h1);
    chk("gaps.acc", 64'(acc_out), 64'd10);
    chk("gaps.count", 64'(count), 64'd4);
    prod_valid = 1'b0;
    acc_ack = 1'b1; tick(); acc_ack = 1'b0;

    // Zero length job.
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    chk("zero.valid", 64'(acc_valid), 64'h1);
    chk("zero.acc", 64'(acc_out), 64'h0);
    acc_ack = 1'b1; tick(); acc_ack = 1'b0;
    chk("zero.busy", 64'(busy), 64'h0);
    chk("zero.valid_drop", 64'(acc_valid), 64'h0);

    // Overflow on the 32-bit instance; 40-bit instance holds the full sum.
    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'hFFFE0001;
    tick(); tick();
    prod_valid = 1'b0;
    tick();
    chk("ovf32.valid", 64'(s_acc_valid), 64'h1);
`ifdef MAC_SAT_EN
    chk("ovf32.acc", 64'(s_acc_out), 64'hFFFFFFFF);
`else
    chk("ovf32.acc", 64'(s_acc_out), 64'hFFFC0002);
`endif
    chk("ovf32.ovf", 64'(s_ovf), 64'h1);
    chk("ovf40.acc", 64'(acc_out), 64'h1FFFC0002);
    chk("ovf40.ovf", 64'(ovf), 64'h0);
    acc_ack = 1'b1; tick(); acc_ack = 1'b0;

    // Start while busy is ignored; async reset mid-job clears everything.
    start = 1'b1; len = 8'd5; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'd5;
    tick(); tick();
    prod_valid = 1'b0;
    chk("busy.count2", 64'(count), 64'd2);
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    chk("busy.start_count", 64'(count), 64'd2);
    chk("busy.start_busy", 64'(busy), 64'h1);
    chk("busy.len_kept", 64'(prod_ready), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk_zero("midrst");
    #3 rst = 1'b0;
    tick();
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'd7; tick(); prod_valid = 1'b0;
    tick();
    chk("fresh.valid", 64'(acc_valid), 64'h1);
    chk("fresh.acc", 64'(acc_out), 64'd7);

    // Result held without ack; start pulses ignored.
    for (int i = 0; i < 10; i++) begin
      start = i[0]; len = 8'd3;
      tick();
      chk("hold.valid", 64'(acc_valid), 64'h1);
      chk("hold.acc", 64'(acc_out), 64'd7);
    end
    start = 1'b0;
    acc_ack = 1'b1; tick(); acc_ack = 1'b0;
    chk("hold.release_busy", 64'(busy), 64'h0);
    chk("hold.release_valid", 64'(acc_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
